// File: rtl/block_draw_ctrl_pkg.sv
// block_draw_ctrl_pkg: shared graphics constants and draw-controller state encoding.
package block_draw_ctrl_pkg;
    localparam int BLOCK_DIM    = 8;
    localparam int BLOCK_PIXELS = BLOCK_DIM * BLOCK_DIM;
    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;
    localparam int COLOUR_W     = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_E,
        ERASE,
        LOAD_D,
        DRAW,
        DONE
    } state_t;
endpackage

// File: rtl/block_draw_ctrl_coord_clamp.sv
// coord_clamp: clamps a block's top-left corner so the whole block stays on screen.
module coord_clamp #(
    parameter int MAX_X = 152,
    parameter int MAX_Y = 112
) (
    input  logic [7:0] x,
    input  logic [6:0] y,
    output logic [7:0] x_c,
    output logic [6:0] y_c
);
    localparam logic [7:0] MX = 8'(MAX_X);
    localparam logic [6:0] MY = 7'(MAX_Y);

    assign x_c = (x > MX) ? MX : x;
    assign y_c = (y > MY) ? MY : y;
endmodule

// File: rtl/block_draw_ctrl.sv
// block_draw_ctrl: sequences 8x8 block draws (optional erase pass, then draw pass)
// into the datapath and VGA adapter, one request at a time.
module block_draw_ctrl
    import block_draw_ctrl_pkg::*;
#(
    parameter int                  SCREEN_W  = SCREEN_W_DEF,
    parameter int                  SCREEN_H  = SCREEN_H_DEF,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = '0
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [7:0]          req_x,
    input  logic [6:0]          req_y,
    input  logic [COLOUR_W-1:0] req_colour,
    input  logic                req_move,
    output logic [7:0]          dp_x,
    output logic [6:0]          dp_y,
    output logic                dp_load,
    output logic                dp_enable,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                plot,
    output logic                done
);
    state_t              state, next;
    logic [5:0]          cnt;
    logic [7:0]          prev_x, new_x, clamp_x;
    logic [6:0]          prev_y, new_y, clamp_y;
    logic [COLOUR_W-1:0] new_colour;
    logic                has_prev, accept, last, erase_ph, draw_ph;

    coord_clamp #(.MAX_X(SCREEN_W - BLOCK_DIM), .MAX_Y(SCREEN_H - BLOCK_DIM)) u_clamp (
        .x   (req_x),
        .y   (req_y),
        .x_c (clamp_x),
        .y_c (clamp_y)
    );

    assign accept = req_valid && req_ready;
    assign last   = cnt == 6'(BLOCK_PIXELS - 1);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= IDLE;
            cnt        <= '0;
            has_prev   <= 1'b0;
            prev_x     <= '0;
            prev_y     <= '0;
            new_x      <= '0;
            new_y      <= '0;
            new_colour <= '0;
        end else begin
            state <= next;
            cnt   <= (state == LOAD_E || state == LOAD_D) ? 6'd0 :
                     (state == ERASE  || state == DRAW)   ? cnt + 6'd1 : cnt;
            if (accept) begin
                new_x      <= clamp_x;
                new_y      <= clamp_y;
                new_colour <= req_colour;
            end
            // The block just drawn becomes the one a later move must erase.
            if (state == DRAW && last) begin
                prev_x   <= new_x;
                prev_y   <= new_y;
                has_prev <= 1'b1;
            end
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = !accept ? IDLE : (req_move && has_prev) ? LOAD_E : LOAD_D;
            LOAD_E:  next = ERASE;
            ERASE:   next = last ? LOAD_D : ERASE;
            LOAD_D:  next = DRAW;
            DRAW:    next = last ? DONE : DRAW;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        erase_ph   = state == LOAD_E || state == ERASE;
        draw_ph    = state == LOAD_D || state == DRAW;
        req_ready  = state == IDLE;
        done       = state == DONE;
        dp_load    = state == LOAD_E || state == LOAD_D;
        dp_enable  = erase_ph || draw_ph;
        plot       = state == ERASE || state == DRAW;
        dp_x       = erase_ph ? prev_x : draw_ph ? new_x : '0;
        dp_y       = erase_ph ? prev_y : draw_ph ? new_y : '0;
        colour_out = erase_ph ? BG_COLOUR : draw_ph ? new_colour : '0;
    end
endmodule

// File: tb/tb_block_draw_ctrl.sv
// tb_block_draw_ctrl: directed table, handshake/reset sequences and randomized
// requests checked against a pixel-list model of what each request should paint.
module tb_block_draw_ctrl;
    logic       clock = 1'b0;
    logic       resetn, req_valid, req_ready, req_move;
    logic [7:0] req_x, dp_x;
    logic [6:0] req_y, dp_y;
    logic [2:0] req_colour, colour_out;
    logic       dp_load, dp_enable, plot, done;
    logic [5:0] pc;

    int tests = 0;
    int fails = 0;

    bit         m_has = 0;
    logic [7:0] m_px  = '0;
    logic [6:0] m_py  = '0;

    typedef struct {
        int x, y, c, m;
        int ex, ey, edone;
    } vec_t;
    vec_t tbl[7];

    block_draw_ctrl dut (
        .clock      (clock),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .req_move   (req_move),
        .dp_x       (dp_x),
        .dp_y       (dp_y),
        .dp_load    (dp_load),
        .dp_enable  (dp_enable),
        .colour_out (colour_out),
        .plot       (plot),
        .done       (done)
    );

    always #5 clock = ~clock;

    // Behaves like the downstream datapath pixel counter.
    always @(posedge clock) begin
        if (!resetn || dp_load) pc <= '0;
        else if (dp_enable)     pc <= pc + 6'd1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_req(input int x, input int y, input int c, input int m, input bit keep,
                           output int dk, output int np, output int lx, output int ly);
        logic [17:0] expq[$];
        logic [17:0] obsq[$];
        int  cx, cy, bad;
        bit  er, busy_ready;
        cx = (x > 152) ? 152 : x;
        cy = (y > 112) ? 112 : y;
        er = (m != 0) && m_has;
        if (er)
            for (int i = 0; i < 64; i++)
                expq.push_back({8'(m_px + i / 8), 7'(m_py + i % 8), 3'b000});
        for (int i = 0; i < 64; i++)
            expq.push_back({8'(cx + i / 8), 7'(cy + i % 8), 3'(c)});
        chk("ready_idle", int'(req_ready), 1);
        req_x = 8'(x); req_y = 7'(y); req_colour = 3'(c); req_move = m[0];
        req_valid = 1'b1;
        @(posedge clock);
        #1;
        req_valid = keep;
        req_x = 8'($urandom); req_y = 7'($urandom); req_colour = 3'($urandom); req_move = 1'($urandom);
        dk = 0; lx = -1; ly = -1; busy_ready = 0;
        for (int k = 1; k <= 200 && dk == 0; k++) begin
            @(negedge clock);
            if (plot) begin
                obsq.push_back({8'(dp_x + 8'(pc[5:3])), 7'(dp_y + 7'(pc[2:0])), colour_out});
                lx = dp_x; ly = dp_y;
            end
            if (req_ready) busy_ready = 1;
            if (done) dk = k;
        end
        chk("done_latency", dk, er ? 131 : 66);
        chk("ready_low_busy", int'(busy_ready), 0);
        chk("plot_count", obsq.size(), expq.size());
        bad = 0;
        for (int i = 0; i < obsq.size() && i < expq.size(); i++)
            if (obsq[i] !== expq[i]) bad++;
        chk("pixels", bad, 0);
        @(negedge clock);
        chk("done_pulse_ready", int'({done, req_ready}), 1);
        m_has = 1; m_px = 8'(cx); m_py = 7'(cy);
        np = obsq.size();
    endtask

    initial begin
        int dk, np, lx, ly, nd, npl;
        tbl[0] = '{10, 20, 4, 0, 10, 20, 66};
        tbl[1] = '{30, 40, 2, 1, 30, 40, 131};
        tbl[2] = '{200, 127, 5, 0, 152, 112, 66};
        tbl[3] = '{0, 0, 7, 1, 0, 0, 131};
        tbl[4] = '{159, 119, 1, 1, 152, 112, 131};
        tbl[5] = '{152, 112, 3, 0, 152, 112, 66};
        tbl[6] = '{151, 111, 6, 1, 151, 111, 131};

        resetn = 0; req_valid = 0; req_x = 0; req_y = 0; req_colour = 0; req_move = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_ctrl", int'({done, dp_load, dp_enable, plot}), 0);
        chk("rst_data", int'({colour_out, dp_x, dp_y}), 0);
        resetn = 1;
        @(negedge clock);

        for (int t = 0; t < 7; t++) begin
            run_req(tbl[t].x, tbl[t].y, tbl[t].c, tbl[t].m, 0, dk, np, lx, ly);
            chk($sformatf("tbl%0d_done", t), dk, tbl[t].edone);
            chk($sformatf("tbl%0d_x", t), lx, tbl[t].ex);
            chk($sformatf("tbl%0d_y", t), ly, tbl[t].ey);
            chk($sformatf("tbl%0d_plots", t), np, tbl[t].edone == 131 ? 128 : 64);
        end

        // Valid held high across three requests.
        run_req(5, 6, 1, 1, 1, dk, np, lx, ly);
        run_req(90, 100, 2, 0, 1, dk, np, lx, ly);
        run_req(250, 3, 3, 1, 0, dk, np, lx, ly);
        nd = 0; npl = 0;
        repeat (20) begin
            @(negedge clock);
            nd += int'(done); npl += int'(plot);
        end
        chk("hold_no_dup", nd + npl, 0);

        // Reset while idle, then a move must draw without erasing.
        resetn = 0;
        @(negedge clock);
        resetn = 1; m_has = 0;
        @(negedge clock);
        run_req(12, 34, 5, 1, 0, dk, np, lx, ly);

        // Reset during DRAW cycle 30.
        req_x = 50; req_y = 60; req_colour = 3; req_move = 0; req_valid = 1;
        @(posedge clock);
        #1 req_valid = 0;
        repeat (31) @(negedge clock);
        chk("mid_plot_before", int'(plot), 1);
        resetn = 0;
        @(negedge clock);
        chk("mid_plot_after", int'({plot, done}), 0);
        resetn = 1; m_has = 0;
        nd = 0; npl = 0;
        repeat (70) begin
            @(negedge clock);
            nd += int'(done); npl += int'(plot);
        end
        chk("mid_no_done", nd + npl, 0);
        run_req(70, 80, 6, 1, 0, dk, np, lx, ly);

        for (int r = 0; r < 20; r++) begin
            run_req(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), 0, dk, np, lx, ly);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/block_draw_ctrl.md
# block_draw_ctrl

Control FSM that issues 8x8 block draws to the graphics datapath and the VGA adapter. It accepts draw requests over a valid/ready handshake and clamps the coordinates to the 160x120 screen. Each draw is sequenced as a load cycle followed by 64 plot cycles. A move request first erases the previously drawn block with the background colour, then draws the new one. The block sits between game logic (the request source) and the datapath/adapter pair (the responder).

## Interface
Parameters:
- SCREEN_W, 160: screen width in pixels.
- SCREEN_H, 120: screen height in pixels.
- BG_COLOUR, 3'b000: colour used for erase passes.

Ports:
- clock, input, 1: single system clock. All logic is on the rising edge.
- resetn, input, 1: synchronous, active-low reset.
- req_valid, input, 1: a request is present.
- req_ready, output, 1: the controller can accept a request.
- req_x, input, 8: block top-left x.
- req_y, input, 7: block top-left y.
- req_colour, input, 3: block colour.
- req_move, input, 1: erase the previous block before drawing.
- dp_x, output, 8: base x to the datapath x_in.
- dp_y, output, 7: base y to the datapath y_in.
- dp_load, output, 1: datapath load; clears the datapath pixel counter.
- dp_enable, output, 1: datapath counter enable.
- colour_out, output, 3: colour to the adapter.
- plot, output, 1: adapter write enable.
- done, output, 1: one-cycle pulse when a request completes.

## Operation
- States: IDLE, LOAD_E, ERASE, LOAD_D, DRAW, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch the clamped coordinates, colour and move flag into the new_* registers.
  - Go to LOAD_E if the move flag is set and has_prev=1; otherwise go to LOAD_D.
- Clamping: x_c = min(req_x, SCREEN_W-8), so 152; y_c = min(req_y, SCREEN_H-8), so 112.
- LOAD_E:
  - dp_x/dp_y = prev_x/prev_y, colour_out=BG_COLOUR.
  - dp_load=1, dp_enable=1, plot=0. Internal 6-bit cnt cleared.
- ERASE:
  - dp_x/dp_y = prev_*, colour_out=BG_COLOUR.
  - dp_enable=1, plot=1, cnt increments each cycle.
  - Exits to LOAD_D in the cycle cnt==63, after 64 plot cycles.
- LOAD_D: same as LOAD_E but using new_x/new_y and new_colour.
- DRAW:
  - Same as ERASE using new_*.
  - On cnt==63, go to DONE.
  - Update prev_x/prev_y ← new_x/new_y and set has_prev=1 on that edge.
- DONE: done=1, req_ready=0, all dp/plot outputs 0. Next state IDLE.
- A non-move request, or a move with has_prev=0, draws without erasing.

## Timing
- Reset values:
  - State IDLE; cnt=0; has_prev=0; prev_*/new_* = 0.
  - Outputs: req_ready=1, done=0, dp_load=0, dp_enable=0, plot=0, colour_out=0, dp_x=0, dp_y=0.
- Request accepted on edge T (non-move):
  - LOAD_D during cycle T+1.
  - DRAW during T+2..T+65, with plot high for exactly 64 cycles.
  - DONE at T+66.
  - req_ready high again at T+67.
- Move with has_prev=1:
  - LOAD_E at T+1, ERASE T+2..T+65.
  - LOAD_D T+66, DRAW T+67..T+130.
  - DONE T+131, ready at T+132.
- Datapath alignment: the datapath pixel counter equals cnt during every plot cycle, giving x = base + cnt[5:3] and y = base + cnt[2:0].
- Handshake:
  - req_ready is combinational from state, high only in IDLE.
  - Request fields are sampled only on the accepting edge; changes while busy are ignored.
  - A request held valid during DONE is accepted in the following IDLE cycle.
  - Back-to-back requests are therefore separated by at least one IDLE cycle.
- All datapath and adapter outputs are Moore (derived from state and registers only).
- Reset mid-operation: on the next edge, state returns to IDLE, plot drops, has_prev clears, and no done pulse is issued.

## Structure
- Shared graphics package:
  - State encoding typedef.
  - BLOCK_DIM=8 and BLOCK_PIXELS=64.
  - SCREEN_W and SCREEN_H defaults.
  - Colour width of 3.
- One natural sub-module, coord_clamp: combinational min() on x/y against the screen limits, reusable by other sprite logic.
- cnt, the prev_*/new_* registers and the FSM stay in this module.

## Test plan
- After reset:
  - Request x=10, y=20, colour=3'b100, move=0.
  - Expect 1 load cycle, then 64 plot cycles with dp_x=10, dp_y=20, colour_out=4.
  - Expect done at T+66 and has_prev=1.
- Move request x=30, y=40, colour=2 after the previous test:
  - Expect 64 plots at (10,20) with colour 0, then 64 plots at (30,40) with colour 2.
  - Expect done at T+131.
- Move request directly after reset: no erase pass; done at T+66.
- Clamp: request x=200, y=127 → dp_x=152, dp_y=112.
- Hold req_valid high continuously: requests complete sequentially; req_ready is low throughout each busy period; no request is lost or duplicated.
- Assert resetn=0 at DRAW cycle 30:
  - Plot is 0 on the next cycle and no done pulse occurs.
  - A subsequent move request performs no erase.
